// File: rtl/lc3x_mult_div_pkg.sv
// Shared types and constants for the LC-3X iterative multiply/divide unit.
// Imported by the interface, the unit and its bench.
package lc3x_mult_div_pkg;

  localparam int MD_WIDTH = 16;
  localparam int MD_ITER  = 16;

  typedef enum logic [1:0] {
    md_none = 2'b00,
    md_mul  = 2'b01,
    md_div  = 2'b10,
    md_rsvd = 2'b11
  } lc3b_md_op;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } md_state_t;

  // Two's-complement magnitude; 0x8000 maps to itself, read as unsigned.
  function automatic logic [MD_WIDTH-1:0] md_abs(input logic [MD_WIDTH-1:0] v);
    return v[MD_WIDTH-1] ? (16'h0000 - v) : v;
  endfunction

endpackage

// File: rtl/lc3x_mult_div_if.sv
// Request/response bundle between the EX stage (master) and the
// multiply/divide unit (slave).
interface lc3x_mult_div_if;
  import lc3x_mult_div_pkg::*;

  logic                start;
  lc3b_md_op           op;
  logic                flush;
  logic [MD_WIDTH-1:0] a;
  logic [MD_WIDTH-1:0] b;
  logic                busy;
  logic                done;
  logic [MD_WIDTH-1:0] result;
  logic                div_by_zero;

  modport master (
    output start, op, flush, a, b,
    input  busy, done, result, div_by_zero
  );

  modport slave (
    input  start, op, flush, a, b,
    output busy, done, result, div_by_zero
  );

endinterface

// File: rtl/lc3x_mult_div.sv
// Iterative 16-cycle shift-add multiplier / restoring signed divider
// sharing one 17-bit accumulator; one result bit per RUN cycle.
module lc3x_mult_div
  import lc3x_mult_div_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  lc3x_mult_div_if.slave md
);

  md_state_t           state_r, state_s;
  logic [3:0]          cnt_r;
  logic [16:0]         acc_r;
  logic [MD_WIDTH-1:0] opa_r;
  logic [MD_WIDTH-1:0] opb_r;
  logic                is_div_r;
  logic                neg_r;
  logic                busy_r;
  logic                done_r;
  logic [MD_WIDTH-1:0] result_r;
  logic                dbz_r;

  logic                accept_s;
  logic                req_div_s;
  logic                div_zero_s;
  logic [16:0]         shifted_s;
  logic                ge_s;
  logic [16:0]         acc_nx_s;
  logic [MD_WIDTH-1:0] opa_nx_s;
  logic [MD_WIDTH-1:0] opb_nx_s;
  logic [MD_WIDTH-1:0] final_s;

  assign accept_s   = md.start & ~md.flush;
  assign req_div_s  = (md.op == md_div);
  assign div_zero_s = req_div_s & (md.b == 16'h0000);

  // One iteration of the shared datapath: mul adds opa under opb's LSB,
  // div shifts the next dividend bit into the remainder and trial-subtracts.
  always_comb begin
    shifted_s = {acc_r[15:0], opa_r[15]};
    ge_s      = (shifted_s >= {1'b0, opb_r});
    acc_nx_s  = acc_r;
    opa_nx_s  = opa_r;
    opb_nx_s  = opb_r;
    final_s   = result_r;
    if (is_div_r) begin
      acc_nx_s = ge_s ? (shifted_s - {1'b0, opb_r}) : shifted_s;
      opa_nx_s = {opa_r[14:0], ge_s};
      final_s  = neg_r ? (16'h0000 - opa_nx_s) : opa_nx_s;
    end else begin
      acc_nx_s = {1'b0, acc_r[15:0] + (opb_r[0] ? opa_r : 16'h0000)};
      opa_nx_s = {opa_r[14:0], 1'b0};
      opb_nx_s = {1'b0, opb_r[15:1]};
      final_s  = acc_nx_s[15:0];
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = div_zero_s ? DONE : RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (md.flush) begin
          state_s = IDLE;
        end else if (cnt_r == 4'(MD_ITER - 1)) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand latch, iteration and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r    <= 4'd0;
      acc_r    <= 17'd0;
      opa_r    <= 16'h0000;
      opb_r    <= 16'h0000;
      is_div_r <= 1'b0;
      neg_r    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= 16'h0000;
      dbz_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            cnt_r    <= 4'd0;
            acc_r    <= 17'd0;
            is_div_r <= req_div_s;
            neg_r    <= md.a[15] ^ md.b[15];
            opa_r    <= req_div_s ? md_abs(md.a) : md.a;
            opb_r    <= req_div_s ? md_abs(md.b) : md.b;
            if (div_zero_s) begin
              result_r <= 16'hFFFF;
              dbz_r    <= 1'b1;
              done_r   <= 1'b1;
            end else begin
              busy_r <= 1'b1;
            end
          end
        end
        RUN: begin
          if (md.flush) begin
            busy_r <= 1'b0;
          end else begin
            cnt_r <= cnt_r + 4'd1;
            acc_r <= acc_nx_s;
            opa_r <= opa_nx_s;
            opb_r <= opb_nx_s;
            if (cnt_r == 4'(MD_ITER - 1)) begin
              busy_r   <= 1'b0;
              done_r   <= 1'b1;
              result_r <= final_s;
              dbz_r    <= 1'b0;
            end
          end
        end
        DONE:    busy_r <= 1'b0;
        default: busy_r <= 1'b0;
      endcase
    end
  end

  assign md.busy        = busy_r;
  // A flush arriving in the DONE cycle still squashes the pulse.
  assign md.done        = done_r & ~md.flush;
  assign md.result      = result_r;
  assign md.div_by_zero = dbz_r;

endmodule
